mem_stage: RTL

- Memory-access stage of the 16-bit pipeline. Sits directly downstream of the EX/MEM register and consumes its outputs.
- Owns the data memory. Performs loads and stores, with optional wait states.
- Resolves branches from Branch/Zero.
- Contains the MEM/WB pipeline register that feeds write-back.
- Raises stall while a multi-cycle access is in progress.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_stage_data_mem.sv | 27 ++
 rtl/mem_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: datapath widths and the
// wait-state FSM encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mem_stage_pkg;

  localparam int DATA_W = 16;  // datapath word width
  localparam int REG_W  = 3;   // register-file index width

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous data RAM for the memory stage.
// Latency: 1 clock read (rdata registered; returns the old word on a write). Backpressure: none.
// Ports: clock; we write enable; addr word index; wdata store data; rdata registered read data.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read happens every edge; on a write the read port sees the pre-edge word.
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data memory loads/stores, branch resolution, MEM/WB register.
// Latency: 1 edge with WAIT_STATES=0, else WAIT_STATES+1 edges per memory access.
// Backpressure: stall held high for WAIT_STATES cycles per access; upstream must hold inputs.
// Ports: clock/reset (sync, active-high); MemRead/MemWrite access requests;
//   MemtoReg/RegWrite/muxRegDst pass-through control; Branch/Zero/outputShiftLeft
//   branch resolution; outputALU address or ALU result; dataRegBank2 store data;
//   PCSrc/branchTarget/stall combinational; *Out signals are the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [DATA_W-1:0] outputALU,
  input  logic [DATA_W-1:0] dataRegBank2,
  input  logic [DATA_W-1:0] outputShiftLeft,
  input  logic [REG_W-1:0]  muxRegDst,
  output logic              PCSrc,
  output logic [DATA_W-1:0] branchTarget,
  output logic              stall,
  output logic [DATA_W-1:0] readDataOut,
  output logic [DATA_W-1:0] outputALUOut,
  output logic [REG_W-1:0]  muxRegDstOut,
  output logic              MemtoRegOut,
  output logic              RegWriteOut
);

  localparam int AW = $clog2(DEPTH);
  // Counter is at least one bit wide so the zero-wait build still elaborates.
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_access;
  logic              w_fire;
  logic              w_stall;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  logic              r_load;
  logic [DATA_W-1:0] r_alu;
  logic [REG_W-1:0]  r_dst;
  logic              r_m2r;
  logic              r_rw;

  assign w_access = MemRead | MemWrite;

  // Branch resolution is independent of the access FSM.
  assign PCSrc        = Branch & Zero;
  assign branchTarget = outputShiftLeft;

  // w_fire marks the single edge at which the access actually executes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_fire      = 1'b0;
    if (WAIT_STATES == 0) begin
      w_fire      = w_access;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            w_stall     = 1'b1;
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CW'(1);
          end
        end
        ST_WAIT: begin
          if (r_cnt != CNT_LAST) begin
            w_stall   = 1'b1;
            w_cnt_nxt = r_cnt + CW'(1);
          end else begin
            w_fire      = w_access;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign stall = w_stall;

  // Reset gates the write so an abandoned store never reaches the array.
  assign w_we = w_fire & MemWrite & ~reset;

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_mem (
    .clock (clock),
    .we    (w_we),
    .addr  (outputALU[AW-1:0]),
    .wdata (dataRegBank2),
    .rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_alu   <= '0;
      r_dst   <= '0;
      r_m2r   <= 1'b0;
      r_rw    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall) begin
        // Bubble into write-back while the access is still in flight.
        r_load <= 1'b0;
        r_alu  <= '0;
        r_dst  <= '0;
        r_m2r  <= 1'b0;
        r_rw   <= 1'b0;
      end else begin
        // Store wins over a simultaneous load, so load data is only kept for pure reads.
        r_load <= w_fire & MemRead & ~MemWrite;
        r_alu  <= outputALU;
        r_dst  <= muxRegDst;
        r_m2r  <= MemtoReg;
        r_rw   <= RegWrite;
      end
    end
  end

  // The RAM output register captures at the same edge as r_load, so together
  // they behave as the MEM/WB load-data field.
  assign readDataOut  = r_load ? w_rdata : '0;
  assign outputALUOut = r_alu;
  assign muxRegDstOut = r_dst;
  assign MemtoRegOut  = r_m2r;
  assign RegWriteOut  = r_rw;

endmodule
